single128_hw_accum: RTL and testbench



---
 rtl/single128_hw_accum_if.sv | 34 +++
 rtl/single128_hw_accum.sv | 135 +++++++++++++
 tb/tb_single128_hw_accum.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/single128_hw_accum_if.sv
// ============================================================================
// Module   : single128_hw_accum_if
// Brief    : Column-tag input and frame-result handshake bundle for the
//            128-bit single-column Hamming-weight accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface single128_hw_accum_if #(
   parameter int SUM_W = 16,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_last;
   logic             last_ready;
   logic [7:0]       comp_out;
   logic             out_valid;
   logic             out_ready;
   logic [SUM_W-1:0] out_sum;
   logic [CNT_W-1:0] out_words;
   logic             out_ovf;

   modport master (
      output in_valid, in_last, comp_out, out_ready,
      input  last_ready, out_valid, out_sum, out_words, out_ovf
   );

   modport slave (
      input  in_valid, in_last, comp_out, out_ready,
      output last_ready, out_valid, out_sum, out_words, out_ovf
   );
endinterface

`default_nettype wire

// File: rtl/single128_hw_accum.sv
// ============================================================================
// Module   : single128_hw_accum
// Brief    : Sums per-column Hamming weights over a frame into a saturating
//            total plus column count, held in a one-entry result buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module single128_hw_accum #(
   parameter int COMP_LAT = 3,
   parameter int SUM_W    = 16,
   parameter int CNT_W    = 16
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   single128_hw_accum_if.slave  bus
);

   localparam int c_PW = $clog2(COMP_LAT + 2);

   logic [COMP_LAT-1:0] r_tag_v;
   logic [COMP_LAT-1:0] r_tag_l;

   logic [SUM_W-1:0]    r_acc_sum;
   logic [CNT_W-1:0]    r_acc_cnt;
   logic                r_acc_ovf;

   logic                r_out_valid;
   logic [SUM_W-1:0]    r_out_sum;
   logic [CNT_W-1:0]    r_out_words;
   logic                r_out_ovf;

   logic                w_arr_valid;
   logic                w_arr_last;
   logic [SUM_W:0]      w_sum_ext;
   logic [CNT_W:0]      w_cnt_ext;
   logic                w_sum_sat;
   logic                w_cnt_sat;
   logic [SUM_W-1:0]    w_sum_next;
   logic [CNT_W-1:0]    w_cnt_next;
   logic                w_ovf_next;
   logic                w_frame_end;
   logic                w_accept;
   logic                w_load;
   logic [c_PW-1:0]     w_pending;

   assign w_arr_valid = r_tag_v[COMP_LAT-1];
   assign w_arr_last  = r_tag_l[COMP_LAT-1];

   // One extra bit on each adder exposes the carry used as the clamp condition.
   assign w_sum_ext  = {1'b0, r_acc_sum} + (SUM_W+1)'(bus.comp_out);
   assign w_cnt_ext  = {1'b0, r_acc_cnt} + (CNT_W+1)'(1);
   assign w_sum_sat  = w_sum_ext[SUM_W];
   assign w_cnt_sat  = w_cnt_ext[CNT_W];
   assign w_sum_next = w_sum_sat ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
   assign w_cnt_next = w_cnt_sat ? {CNT_W{1'b1}} : w_cnt_ext[CNT_W-1:0];
   assign w_ovf_next = r_acc_ovf | w_sum_sat | w_cnt_sat;

   assign w_frame_end = w_arr_valid & w_arr_last;
   assign w_accept    = r_out_valid & bus.out_ready;
   assign w_load      = w_frame_end & (~r_out_valid | bus.out_ready);

   always_comb begin
      w_pending = c_PW'(r_out_valid);
      for (int i = 0; i < COMP_LAT; i++) begin
         w_pending = w_pending + c_PW'(r_tag_l[i]);
      end
   end

   assign bus.last_ready = (w_pending == c_PW'(0)) ||
                           ((w_pending == c_PW'(1)) && r_out_valid && bus.out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_v <= '0;
         r_tag_l <= '0;
      end else begin
         r_tag_v[0] <= bus.in_valid;
         r_tag_l[0] <= bus.in_valid & bus.in_last;
         for (int i = 1; i < COMP_LAT; i++) begin
            r_tag_v[i] <= r_tag_v[i-1];
            r_tag_l[i] <= r_tag_l[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_sum <= '0;
         r_acc_cnt <= '0;
         r_acc_ovf <= 1'b0;
      end else if (w_arr_valid) begin
         if (w_arr_last) begin
            r_acc_sum <= '0;
            r_acc_cnt <= '0;
            r_acc_ovf <= 1'b0;
         end else begin
            r_acc_sum <= w_sum_next;
            r_acc_cnt <= w_cnt_next;
            r_acc_ovf <= w_ovf_next;
         end
      end
   end

   // A frame end that finds the buffer full and not draining is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_words <= '0;
         r_out_ovf   <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_sum   <= w_sum_next;
         r_out_words <= w_cnt_next;
         r_out_ovf   <= w_ovf_next;
      end else if (w_accept) begin
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_words <= '0;
         r_out_ovf   <= 1'b0;
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_out_sum;
   assign bus.out_words = r_out_words;
   assign bus.out_ovf   = r_out_ovf;

   a_last_credit: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.in_valid && bus.in_last && !bus.last_ready));

endmodule

`default_nettype wire

// File: tb/tb_single128_hw_accum.sv
// ============================================================================
// Module   : tb_single128_hw_accum
// Brief    : Scoreboard bench driving a 16-bit and an 8-bit-sum instance in
//            lockstep behind a modelled fixed-latency compressor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_single128_hw_accum;

   localparam int c_LAT = 3;

   typedef struct {
      int sum16;
      int sum8;
      int words;
      bit ovf16;
      bit ovf8;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] col = 8'd0;
   logic [7:0] pipe [c_LAT];

   int n_checks = 0;
   int n_fail   = 0;
   exp_t q[$];

   int  m16 = 0, m8 = 0, mcnt = 0;
   bit  mo16 = 0, mo8 = 0;

   single128_hw_accum_if #(.SUM_W(16), .CNT_W(16)) a16 ();
   single128_hw_accum_if #(.SUM_W(8),  .CNT_W(16)) a8 ();

   single128_hw_accum #(.COMP_LAT(c_LAT), .SUM_W(16), .CNT_W(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .bus(a16.slave));
   single128_hw_accum #(.COMP_LAT(c_LAT), .SUM_W(8), .CNT_W(16)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .bus(a8.slave));

   always #5 clk = ~clk;

   // Compressor model: the column weight appears c_LAT edges after sampling.
   always @(posedge clk) begin
      pipe[0] <= col;
      for (int i = 1; i < c_LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign a16.comp_out = pipe[c_LAT-1];
   assign a8.comp_out  = pipe[c_LAT-1];
   assign a8.in_valid  = a16.in_valid;
   assign a8.in_last   = a16.in_last;
   assign a8.out_ready = a16.out_ready;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m16 = 0; m8 = 0; mcnt = 0; mo16 = 0; mo8 = 0;
   endtask

   // Drives one cycle; a last column is held back until credit is available.
   task automatic drive_col(input logic [7:0] v, input bit valid, input bit last);
      int k = 0;
      exp_t e;
      if (valid && last) begin
         while (!a16.last_ready && k < 50) begin
            @(posedge clk); #1; k++;
         end
         if (!a16.last_ready) check_eq("credit_timeout", 32'(a16.last_ready), 1);
      end
      a16.in_valid = valid;
      a16.in_last  = last;
      col          = valid ? v : 8'($urandom_range(0, 255));
      if (valid) begin
         m16 += v; m8 += v; mcnt++;
         if (m16 > 65535) begin m16 = 65535; mo16 = 1; end
         if (m8 > 255)    begin m8 = 255;    mo8 = 1;  end
         if (last) begin
            e.sum16 = m16; e.sum8 = m8; e.words = mcnt; e.ovf16 = mo16; e.ovf8 = mo8;
            q.push_back(e);
            model_clear();
         end
      end
      @(posedge clk); #1;
      a16.in_valid = 1'b0;
      a16.in_last  = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_col(8'd0, 1'b0, 1'b0);
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!a16.out_valid && k < 50) begin
         @(posedge clk); #1; k++;
      end
      check_eq("wait_valid", 32'(a16.out_valid), 1);
   endtask

   task automatic wait_drain();
      int k = 0;
      while (q.size() != 0 && k < 100) begin
         @(posedge clk); #1; k++;
      end
      check_eq("drain", q.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && a16.out_valid && a16.out_ready) begin
         if (q.size() == 0) begin
            check_eq("spurious_result", 32'(a16.out_valid), 0);
         end else begin
            e = q.pop_front();
            check_eq("sum16",   32'(a16.out_sum),   e.sum16);
            check_eq("words16", 32'(a16.out_words), e.words);
            check_eq("ovf16",   32'(a16.out_ovf),   32'(e.ovf16));
            check_eq("valid8",  32'(a8.out_valid),  1);
            check_eq("sum8",    32'(a8.out_sum),    e.sum8);
            check_eq("words8",  32'(a8.out_words),  e.words);
            check_eq("ovf8",    32'(a8.out_ovf),    32'(e.ovf8));
         end
      end
   end

   initial begin
      a16.in_valid  = 1'b0;
      a16.in_last   = 1'b0;
      a16.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(a16.out_valid), 0);
      check_eq("rst_ready", 32'(a16.last_ready), 1);
      check_eq("rst_sum",   32'(a16.out_sum), 0);
      check_eq("rst_words", 32'(a16.out_words), 0);
      rst_n = 1'b1;
      idle(4);

      // Basic frame and latency: last sampled at edge S, result after S+c_LAT.
      drive_col(8'd128, 1, 0);
      drive_col(8'd0,   1, 0);
      drive_col(8'd37,  1, 0);
      drive_col(8'd5,   1, 1);
      for (int k = 1; k <= 5; k++) begin
         check_eq($sformatf("lat_valid_%0d", k), 32'(a16.out_valid), 32'(k == c_LAT + 1 ? 1 : 0));
         @(posedge clk); #1;
      end

      // Back-to-back frames.
      drive_col(8'd10, 1, 1);
      drive_col(8'd20, 1, 0);
      drive_col(8'd30, 1, 1);
      idle(10);
      wait_drain();

      // Held result with consumer stalled.
      a16.out_ready = 1'b0;
      drive_col(8'd10, 1, 1);
      wait_valid();
      for (int k = 0; k < 20; k++) begin
         check_eq("hold_ready", 32'(a16.last_ready), 0);
         check_eq("hold_sum",   32'(a16.out_sum), 10);
         @(posedge clk); #1;
      end
      a16.out_ready = 1'b1;
      #1;
      check_eq("release_ready", 32'(a16.last_ready), 1);
      drive_col(8'd3, 1, 1);
      idle(8);
      wait_drain();

      // Saturation in the 8-bit instance, then ovf clears next frame.
      drive_col(8'd128, 1, 0);
      drive_col(8'd128, 1, 1);
      drive_col(8'd3,   1, 1);
      idle(8);
      wait_drain();

      // Bubbles inside a frame.
      drive_col(8'd7, 1, 0);
      idle(2);
      drive_col(8'd9, 1, 0);
      idle(1);
      drive_col(8'd1, 1, 1);
      idle(8);
      wait_drain();

      // Reset mid-frame with a result held.
      a16.out_ready = 1'b0;
      drive_col(8'd9, 1, 1);
      wait_valid();
      drive_col(8'd1, 1, 0);
      drive_col(8'd2, 1, 0);
      rst_n = 1'b0;
      #1;
      check_eq("mrst_valid", 32'(a16.out_valid), 0);
      check_eq("mrst_ready", 32'(a16.last_ready), 1);
      check_eq("mrst_sum",   32'(a16.out_sum), 0);
      q.delete();
      model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      a16.out_ready = 1'b1;
      drive_col(8'd4, 1, 0);
      drive_col(8'd4, 1, 1);
      idle(8);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
